// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port synchronous RAM between fetch and load/store.
// One transaction in flight; data wins contention unless a pending fetch has been starved MAX_WAIT times.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    // state | meaning
    // IDLE  | no transaction outstanding; arbitrate and issue combinationally
    // WAIT  | waiting MEM_LAT cycles for the memory response of the owner
    typedef enum logic {IDLE, WAIT} state_t;

    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(MAX_WAIT + 1);

    state_t           state, state_nxt;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_nxt;
    logic [STV_W-1:0] starve, starve_nxt;
    logic             owner_data, owner_data_nxt;
    logic             owner_we, owner_we_nxt;
    logic             fetch_starved;
    logic             pick_data;
    logic             pick_fetch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve     <= '0;
            owner_data <= 1'b0;
            owner_we   <= 1'b0;
        end else begin
            state      <= state_nxt;
            lat_cnt    <= lat_cnt_nxt;
            starve     <= starve_nxt;
            owner_data <= owner_data_nxt;
            owner_we   <= owner_we_nxt;
        end
    end

    // Grants are gated by reset so every output reads 0 while reset is held.
    always_comb begin
        state_nxt      = state;
        lat_cnt_nxt    = lat_cnt;
        starve_nxt     = starve;
        owner_data_nxt = owner_data;
        owner_we_nxt   = owner_we;
        if_gnt         = 1'b0;
        d_gnt          = 1'b0;
        if_rvalid      = 1'b0;
        d_rvalid       = 1'b0;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_be         = '0;

        fetch_starved = (starve == STV_W'(MAX_WAIT));
        pick_data     = !reset && d_req && !(if_req && fetch_starved);
        pick_fetch    = !reset && if_req && !pick_data;

        case (state)
            IDLE: begin
                if (pick_data) begin
                    d_gnt          = 1'b1;
                    mem_en         = 1'b1;
                    mem_we         = d_we;
                    mem_addr       = d_addr;
                    mem_wdata      = d_wdata;
                    mem_be         = d_be;
                    owner_data_nxt = 1'b1;
                    owner_we_nxt   = d_we;
                    lat_cnt_nxt    = LAT_W'(MEM_LAT);
                    state_nxt      = WAIT;
                end else if (pick_fetch) begin
                    if_gnt         = 1'b1;
                    mem_en         = 1'b1;
                    mem_addr       = if_addr;
                    mem_be         = '1;
                    owner_data_nxt = 1'b0;
                    owner_we_nxt   = 1'b0;
                    lat_cnt_nxt    = LAT_W'(MEM_LAT);
                    state_nxt      = WAIT;
                end
            end
            WAIT: begin
                lat_cnt_nxt = lat_cnt - LAT_W'(1);
                if (lat_cnt == LAT_W'(1)) begin
                    if (owner_data) d_rvalid  = 1'b1;
                    else            if_rvalid = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (!if_req || if_gnt)
            starve_nxt = '0;
        else if (d_gnt && !fetch_starved)
            starve_nxt = starve + STV_W'(1);
    end

    assign if_rdata = if_rvalid ? mem_rdata : '0;
    assign d_rdata  = (d_rvalid && !owner_we) ? mem_rdata : '0;
    assign busy     = (state == WAIT);

endmodule
